// File: rtl/div_pkg.sv
// Shared encodings and constants for the radix-2 online divider:
// phase codes, signed-digit codes, selection thresholds and widths.
package div_pkg;

  localparam int UPW_DEF    = 6;
  localparam int CNT_W      = 7;
  localparam int SEL_POS_TH = 2;   // +1/2 in quarter units
  localparam int SEL_NEG_TH = -2;  // -1/2 in quarter units

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_INIT  = 2'b10,
    ST_RECUR = 2'b01,
    ST_FINAL = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    DIG_ZERO = 2'b00,
    DIG_NEG  = 2'b01,
    DIG_POS  = 2'b10
  } digit_e;

endpackage

// File: rtl/otf_converter.sv
// On-the-fly conversion of signed quotient digits into a two's-complement value.
// Q holds the converted quotient and QM holds Q minus one ulp, so no carry propagation is ever needed.
module otf_converter
  import div_pkg::*;
#(
  parameter int N_DIGITS = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_clear,
  input  logic                i_en,
  input  digit_e              i_digit,
  output logic [N_DIGITS-1:0] o_q
);

  logic [N_DIGITS-1:0] r_q;
  logic [N_DIGITS-1:0] r_qm;
  logic [N_DIGITS-1:0] w_q_nxt;
  logic [N_DIGITS-1:0] w_qm_nxt;

  always_comb begin
    w_q_nxt  = N_DIGITS'({r_q, 1'b0});
    w_qm_nxt = N_DIGITS'({r_qm, 1'b1});
    case (i_digit)
      DIG_POS: begin
        w_q_nxt  = N_DIGITS'({r_q, 1'b1});
        w_qm_nxt = N_DIGITS'({r_q, 1'b0});
      end
      DIG_NEG: begin
        w_q_nxt  = N_DIGITS'({r_qm, 1'b1});
        w_qm_nxt = N_DIGITS'({r_qm, 1'b0});
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_q  <= '0;
      r_qm <= '1;
    end else if (i_en) begin
      r_q  <= w_q_nxt;
      r_qm <= w_qm_nxt;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/q_digit_select.sv
// Quotient-digit selection and phase sequencing of the radix-2 online divider.
// state    | meaning
// IDLE  00 | waiting for start
// INIT  10 | consuming DELTA residual beats, no digits emitted
// RECUR 01 | one digit selected and emitted per accepted beat
// FINAL 11 | draining the last digit, then pulse quot_done
module q_digit_select
  import div_pkg::*;
#(
  parameter int N_DIGITS = 32,
  parameter int DELTA    = 3,
  parameter int UPW      = UPW_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [UPW-1:0]      v_upper_plus,
  input  logic [UPW-1:0]      v_upper_minus,
  input  logic                v_valid,
  output logic                v_ready,
  output logic [1:0]          STATE,
  output logic [CNT_W-1:0]    computation_cycle,
  output logic                q_plus,
  output logic                q_minus,
  output logic                q_valid,
  input  logic                q_ready,
  output logic [N_DIGITS-1:0] quot,
  output logic                quot_done,
  output logic                busy
);

  // Residual estimate in quarter units; the extra integer width rules out overflow.
  function automatic digit_e select_digit(input logic [UPW-1:0] vp, input logic [UPW-1:0] vm);
    int y;
    y = int'($signed(vp)) - int'($signed(vm));
    if (y >= SEL_POS_TH)     return DIG_POS;
    else if (y < SEL_NEG_TH) return DIG_NEG;
    else                     return DIG_ZERO;
  endfunction

  state_e           r_state;
  state_e           w_state_nxt;
  logic [CNT_W-1:0] r_cycle;
  logic [CNT_W-1:0] w_cycle_nxt;
  digit_e           r_digit;
  digit_e           w_digit_nxt;
  digit_e           w_sel;
  logic             r_q_valid;
  logic             w_q_valid_nxt;
  logic             r_quot_done;
  logic             w_quot_done_nxt;
  logic             w_v_ready;
  logic             w_accept;
  logic             w_clear;
  logic             w_otf_en;

  always_comb begin
    w_v_ready       = ((r_state == ST_INIT) || (r_state == ST_RECUR)) && (!r_q_valid || q_ready);
    w_accept        = v_valid && w_v_ready;
    w_sel           = select_digit(v_upper_plus, v_upper_minus);
    w_state_nxt     = r_state;
    w_cycle_nxt     = r_cycle;
    w_digit_nxt     = r_digit;
    w_q_valid_nxt   = r_q_valid;
    w_quot_done_nxt = 1'b0;
    w_clear         = 1'b0;
    w_otf_en        = 1'b0;

    if (r_q_valid && q_ready) begin
      w_q_valid_nxt = 1'b0;
      w_digit_nxt   = DIG_ZERO;
    end

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_INIT;
          w_cycle_nxt = '0;
          w_clear     = 1'b1;
        end
      end
      ST_INIT: begin
        if (w_accept) begin
          if (r_cycle == CNT_W'(DELTA - 1)) begin
            w_state_nxt = ST_RECUR;
            w_cycle_nxt = '0;
          end else begin
            w_cycle_nxt = r_cycle + CNT_W'(1);
          end
        end
      end
      ST_RECUR: begin
        if (w_accept) begin
          w_digit_nxt   = w_sel;
          w_q_valid_nxt = 1'b1;
          w_otf_en      = 1'b1;
          w_cycle_nxt   = r_cycle + CNT_W'(1);
          if (r_cycle == CNT_W'(N_DIGITS - 1)) w_state_nxt = ST_FINAL;
        end
      end
      ST_FINAL: begin
        if (!r_q_valid || q_ready) begin
          w_quot_done_nxt = 1'b1;
          w_state_nxt     = ST_IDLE;
          w_cycle_nxt     = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cycle     <= '0;
      r_digit     <= DIG_ZERO;
      r_q_valid   <= 1'b0;
      r_quot_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cycle     <= w_cycle_nxt;
      r_digit     <= w_digit_nxt;
      r_q_valid   <= w_q_valid_nxt;
      r_quot_done <= w_quot_done_nxt;
    end
  end

  otf_converter #(.N_DIGITS(N_DIGITS)) u_otf (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_clear),
    .i_en    (w_otf_en),
    .i_digit (w_sel),
    .o_q     (quot)
  );

  assign v_ready             = w_v_ready;
  assign STATE               = r_state;
  assign computation_cycle   = r_cycle;
  assign {q_plus, q_minus}   = r_digit;
  assign q_valid             = r_q_valid;
  assign quot_done           = r_quot_done;
  assign busy                = (r_state != ST_IDLE);

endmodule
